// File: rtl/nand_seq_pkg.sv
// Shared types and helpers for the NAND gate stimulus sequencer.
package nand_seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        DONE  = 2'd2
    } nand_seq_state_t;

    localparam int NUM_VEC = 4;

    // Golden response of a healthy 2-input NAND gate.
    function automatic logic nand_expected(input logic a, input logic b);
        return ~(a & b);
    endfunction

endpackage

// File: rtl/nand_seq_dwell_timer.sv
// Dwell timer: counts clocks spent on the current vector and flags the
// final dwell clock, on which the gate output is sampled.
module nand_seq_dwell_timer #(
    parameter int DWELL_CYCLES = 10
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic last
);

    localparam int CNT_W = $clog2(DWELL_CYCLES + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DWELL_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign last = en && (cnt_q == LAST_CNT);

    // Next count: restart on clear or after the last dwell clock, else count up.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = last ? '0 : cnt_q + CNT_W'(1);
        end
    end

    // Count register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/nand_gate_sequencer.sv
// Clocked stimulus controller for a 2-input NAND gate: sweeps (a,b) through
// 00,10,01,11, holds each vector DWELL_CYCLES clocks and checks the gate
// output on the last dwell clock.
// Optional feature macro: NAND_SEQ_ERRCNT_EN adds a saturating err_cnt port.
module nand_gate_sequencer
    import nand_seq_pkg::*;
#(
    parameter int DWELL_CYCLES = 10
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    output logic               gate_a,
    output logic               gate_b,
    input  logic               gate_out,
    output logic               busy,
    output logic               done,
    output logic               pass,
    output logic [NUM_VEC-1:0] fail_vec
`ifdef NAND_SEQ_ERRCNT_EN
    ,
    output logic [7:0]         err_cnt
`endif
);

    nand_seq_state_t    state_q, state_d;
    logic [1:0]         vec_q, vec_d;
    logic [NUM_VEC-1:0] fail_vec_q, fail_vec_d;
    logic               pass_q, pass_d;
    logic               done_q, done_d;
    logic               timer_clr;
    logic               timer_en;
    logic               dwell_last;
    logic               mismatch;

    nand_seq_dwell_timer #(
        .DWELL_CYCLES(DWELL_CYCLES)
    ) u_dwell_timer (
        .clk (clk),
        .rst (rst),
        .clr (timer_clr),
        .en  (timer_en),
        .last(dwell_last)
    );

    assign timer_en = (state_q == DRIVE);

    // The gate inputs come straight from the vector register, so they only
    // move on vector transitions and never glitch.
    assign gate_a   = vec_q[0];
    assign gate_b   = vec_q[1];
    assign busy     = (state_q != IDLE);
    assign done     = done_q;
    assign pass     = pass_q;
    assign fail_vec = fail_vec_q;

    // Sweep control: accept start in IDLE, sample and advance in DRIVE,
    // report for one clock in DONE.
    always_comb begin
        state_d    = state_q;
        vec_d      = vec_q;
        fail_vec_d = fail_vec_q;
        pass_d     = pass_q;
        done_d     = 1'b0;
        timer_clr  = 1'b0;
        mismatch   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d    = DRIVE;
                    vec_d      = 2'd0;
                    fail_vec_d = '0;
                    pass_d     = 1'b0;
                    timer_clr  = 1'b1;
                end
            end
            DRIVE: begin
                if (dwell_last) begin
                    mismatch = (gate_out != nand_expected(vec_q[0], vec_q[1]));
                    if (mismatch) begin
                        fail_vec_d[vec_q] = 1'b1;
                    end
                    if (vec_q == 2'(NUM_VEC - 1)) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                        pass_d  = (fail_vec_d == '0);
                    end else begin
                        vec_d = vec_q + 2'd1;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
                vec_d   = 2'd0;
            end
            default: begin
                state_d = IDLE;
                vec_d   = 2'd0;
            end
        endcase
    end

    // State and result registers; reset discards any sweep in progress.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            vec_q      <= 2'd0;
            fail_vec_q <= '0;
            pass_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            vec_q      <= vec_d;
            fail_vec_q <= fail_vec_d;
            pass_q     <= pass_d;
            done_q     <= done_d;
        end
    end

`ifdef NAND_SEQ_ERRCNT_EN
    logic [7:0] err_cnt_q, err_cnt_d;

    assign err_cnt = err_cnt_q;

    // Lifetime mismatch tally; survives start, saturates instead of wrapping.
    always_comb begin
        err_cnt_d = err_cnt_q;
        if (mismatch && (err_cnt_q != 8'hFF)) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end
    end

    // Error counter register, cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_cnt_q <= 8'd0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end
`else
    // Without the error counter, mismatches are reported only through fail_vec.
`endif

endmodule
